// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Purpose  : Shared opcode/ALU encodings, the decoded control bundle type
//             and the pure decode function for the 9-bit ISA.
//  Contents : OPC_* primary opcodes (instr[8:6]), ALU_* opcodes, DEST_*
//             fixed destinations, ctrl_t bundle, decode_fn().
//  Revision : 1.0  initial release
// ============================================================================
package decode_pkg;

    localparam int CTRL_DEST_W = 4;

    // Primary opcode field instr[8:6]
    localparam logic [2:0] OPC_MOVE   = 3'b000;
    localparam logic [2:0] OPC_LOAD   = 3'b001;
    localparam logic [2:0] OPC_STORE  = 3'b010;
    localparam logic [2:0] OPC_REDXOR = 3'b011;
    localparam logic [2:0] OPC_ALUI   = 3'b100;  // addi / lsl
    localparam logic [2:0] OPC_SHPM   = 3'b101;  // lsr / pm
    localparam logic [2:0] OPC_ARITH  = 3'b110;  // add / xor
    localparam logic [2:0] OPC_BRCP   = 3'b111;  // beqr / copy

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_CMP  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_RXOR = 3'b011;
    localparam logic [2:0] ALU_PM   = 3'b100;
    localparam logic [2:0] ALU_LSL  = 3'b101;
    localparam logic [2:0] ALU_LSR  = 3'b110;

    // Fixed destinations used by the implicit-register instructions
    localparam logic [CTRL_DEST_W-1:0] DEST_MOVE  = 4'b1000;
    localparam logic [CTRL_DEST_W-1:0] DEST_ACC   = 4'b1001;
    localparam logic [CTRL_DEST_W-1:0] DEST_IMM   = 4'b1010;
    localparam logic [CTRL_DEST_W-1:0] DEST_SHIFT = 4'b1011;

    typedef struct packed {
        logic [2:0]             op;
        logic                   regwrite;
        logic                   memwrite;
        logic                   alusrc;
        logic                   move;
        logic                   copy;
        logic                   load;
        logic                   branch;
        logic                   dsel;
        logic [CTRL_DEST_W-1:0] dest;
    } ctrl_t;

    function automatic ctrl_t decode_fn(input logic [8:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[8:6])
            OPC_MOVE: begin
                c.op = ALU_ADD; c.regwrite = 1'b1; c.move = 1'b1; c.dest = DEST_MOVE;
            end
            OPC_LOAD: begin
                c.op = ALU_ADD; c.regwrite = 1'b1; c.load = 1'b1;
                c.dest = {1'b0, instr[5:3]};
            end
            OPC_STORE: begin
                c.op = ALU_ADD; c.memwrite = 1'b1;
            end
            OPC_REDXOR: begin
                c.op = ALU_RXOR; c.regwrite = 1'b1; c.dest = {1'b0, instr[2:0]};
            end
            OPC_ALUI: begin
                c.regwrite = 1'b1;
                if (instr[5]) begin c.op = ALU_LSL; c.dest = DEST_SHIFT; end
                else          begin c.op = ALU_ADD; c.dest = DEST_IMM;   end
            end
            OPC_SHPM: begin
                c.regwrite = 1'b1;
                if (instr[5]) begin c.op = ALU_PM; c.alusrc = 1'b1; c.dest = DEST_ACC; end
                else          begin c.op = ALU_LSR; c.dest = DEST_SHIFT; end
            end
            OPC_ARITH: begin
                c.regwrite = 1'b1; c.alusrc = 1'b1;
                if (instr[5]) begin c.op = ALU_XOR; c.dest = DEST_SHIFT; end
                else          begin c.op = ALU_ADD; c.dest = DEST_ACC;   end
            end
            OPC_BRCP: begin
                if (instr[5]) begin
                    c.op = ALU_ADD; c.regwrite = 1'b1; c.alusrc = 1'b1;
                    c.copy = 1'b1; c.dsel = 1'b1; c.dest = {1'b0, instr[2:0]};
                end else begin
                    c.op = ALU_CMP; c.branch = 1'b1;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_load_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : load_scoreboard
//  Purpose  : Tracks destinations of issued loads for LOAD_LAT cycles so the
//             decode stage can hold back instructions that read them early.
//  Ports    : clk, rst_n      clock, async active-low reset
//             push, push_dest record a load issuing this cycle
//             addr_a, addr_b  source registers to look up
//             hit             either address matches a pending load
//  Revision : 1.0  initial release
// ============================================================================
module load_scoreboard
    import decode_pkg::*;
#(
    parameter int LOAD_LAT = 2,
    parameter int DEST_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DEST_W-1:0] push_dest,
    input  logic [DEST_W-1:0] addr_a,
    input  logic [DEST_W-1:0] addr_b,
    output logic              hit
);

    logic [LOAD_LAT-1:0]             r_v;
    logic [LOAD_LAT-1:0][DEST_W-1:0] r_d;

    // Entry 0 takes this cycle's push (or an empty slot); every entry ages
    // by one each cycle and the oldest simply falls off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            r_d <= '0;
        end else begin
            for (int i = LOAD_LAT - 1; i > 0; i--) begin
                r_v[i] <= r_v[i-1];
                r_d[i] <= r_d[i-1];
            end
            r_v[0] <= push;
            r_d[0] <= push_dest;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (r_v[i] && ((r_d[i] == addr_a) || (r_d[i] == addr_b))) begin
                hit = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : Registered decode stage for the 9-bit ISA with valid/ready
//             handshakes, load-use hazard hold-off and branch flush.
//  Ports    : Clk, Reset_n            clock, async active-low reset
//             in_valid/in_ready/in_instr   upstream instruction handshake
//             flush                   kill output bundle, block acceptance
//             out_valid/out_ready     downstream bundle handshake
//             out_op, out_* controls, out_dest/srca/srcb  decoded bundle
//             stall_cnt               saturating count of hazard cycles
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int LOAD_LAT = 2,
    parameter int DEST_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_op,
    output logic              out_regwrite,
    output logic              out_memwrite,
    output logic              out_alusrc,
    output logic              out_move,
    output logic              out_copy,
    output logic              out_load,
    output logic              out_branch,
    output logic              out_dsel,
    output logic [DEST_W-1:0] out_dest,
    output logic [DEST_W-1:0] out_srca,
    output logic [DEST_W-1:0] out_srcb,
    output logic [CNT_W-1:0]  stall_cnt
);

    ctrl_t             w_dec;
    ctrl_t             r_ctrl;
    logic              r_valid;
    logic [DEST_W-1:0] r_srca;
    logic [DEST_W-1:0] r_srcb;
    logic [CNT_W-1:0]  r_stall;

    logic [DEST_W-1:0] w_srca;
    logic [DEST_W-1:0] w_srcb;
    logic [DEST_W-1:0] w_out_dest;
    logic              w_fire;
    logic              w_push;
    logic              w_sb_hit;
    logic              w_pend_hit;
    logic              w_hazard;
    logic              w_ready;
    logic              w_accept;

    assign w_dec      = decode_fn(in_instr);
    assign w_srca     = DEST_W'(in_instr[5:3]);
    assign w_srcb     = DEST_W'(in_instr[2:0]);
    assign w_out_dest = DEST_W'(r_ctrl.dest);

    // A load issues when downstream takes it, even if a flush arrives in the
    // same cycle; a load killed before issue never reaches the scoreboard.
    assign w_fire = r_valid && out_ready;
    assign w_push = w_fire && r_ctrl.load;

    load_scoreboard #(
        .LOAD_LAT (LOAD_LAT),
        .DEST_W   (DEST_W)
    ) u_scoreboard (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .push      (w_push),
        .push_dest (w_out_dest),
        .addr_a    (w_srca),
        .addr_b    (w_srcb),
        .hit       (w_sb_hit)
    );

    // A load still sitting in the output register has not issued yet, so it
    // is invisible to the scoreboard and must be checked separately.
    assign w_pend_hit = r_valid && r_ctrl.load &&
                        ((w_out_dest == w_srca) || (w_out_dest == w_srcb));
    assign w_hazard   = in_valid && (w_sb_hit || w_pend_hit);
    assign w_ready    = Reset_n && !flush && !w_hazard && (!r_valid || out_ready);
    assign w_accept   = in_valid && w_ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_srca  <= '0;
            r_srcb  <= '0;
            r_stall <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end

            // Acceptance implies the register is empty or draining, so the
            // held bundle never changes under back-pressure.
            if (w_accept) begin
                r_ctrl <= w_dec;
                r_srca <= w_srca;
                r_srcb <= w_srcb;
            end

            if (w_hazard && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign in_ready     = w_ready;
    assign out_valid    = r_valid;
    assign out_op       = r_ctrl.op;
    assign out_regwrite = r_ctrl.regwrite;
    assign out_memwrite = r_ctrl.memwrite;
    assign out_alusrc   = r_ctrl.alusrc;
    assign out_move     = r_ctrl.move;
    assign out_copy     = r_ctrl.copy;
    assign out_load     = r_ctrl.load;
    assign out_branch   = r_ctrl.branch;
    assign out_dsel     = r_ctrl.dsel;
    assign out_dest     = w_out_dest;
    assign out_srca     = r_srca;
    assign out_srcb     = r_srcb;
    assign stall_cnt    = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Self-checking bench for decode_stage: decode table sweep,
//             load-use stall, back-pressure, flush, async reset, and a
//             randomized run against a cycle-indexed reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    localparam int LOAD_LAT = 2;
    localparam int DEST_W   = 4;
    localparam int CNT_W    = 16;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [8:0]        in_instr;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_op;
    logic              out_regwrite, out_memwrite, out_alusrc, out_move;
    logic              out_copy, out_load, out_branch, out_dsel;
    logic [DEST_W-1:0] out_dest, out_srca, out_srcb;
    logic [CNT_W-1:0]  stall_cnt;

    decode_stage #(.LOAD_LAT(LOAD_LAT), .DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_regwrite(out_regwrite), .out_memwrite(out_memwrite),
        .out_alusrc(out_alusrc), .out_move(out_move), .out_copy(out_copy),
        .out_load(out_load), .out_branch(out_branch), .out_dsel(out_dsel),
        .out_dest(out_dest), .out_srca(out_srca), .out_srcb(out_srcb),
        .stall_cnt(stall_cnt)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // {op, regwrite,memwrite,alusrc,move,copy,load,branch,dsel, dest, srca, srcb}
    logic [22:0] act_bundle;
    assign act_bundle = {out_op, out_regwrite, out_memwrite, out_alusrc, out_move,
                         out_copy, out_load, out_branch, out_dsel,
                         out_dest, out_srca, out_srcb};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- decode reference tables (indexed by {instr[8:6],instr[5]})
    logic [2:0] ref_op   [16];
    logic [7:0] ref_ctl  [16];
    int         ref_dsel [16];   // 0 fixed, 1 = instr[5:3], 2 = instr[2:0]
    logic [3:0] ref_dfix [16];

    task automatic set_row(input int idx, input logic [2:0] op, input logic [7:0] ctl,
                           input int dsel, input logic [3:0] dfix);
        ref_op[idx] = op; ref_ctl[idx] = ctl; ref_dsel[idx] = dsel; ref_dfix[idx] = dfix;
    endtask

    function automatic logic [22:0] exp_bundle(input logic [8:0] ins);
        int idx;
        logic [3:0] d;
        idx = int'({ins[8:6], ins[5]});
        if (ref_dsel[idx] == 1)      d = {1'b0, ins[5:3]};
        else if (ref_dsel[idx] == 2) d = {1'b0, ins[2:0]};
        else                         d = ref_dfix[idx];
        return {ref_op[idx], ref_ctl[idx], d, {1'b0, ins[5:3]}, {1'b0, ins[2:0]}};
    endfunction

    // ---------------- sweep vectors
    typedef struct {
        logic [8:0] instr;
        logic [2:0] op;
        logic [7:0] ctl;
        logic [3:0] dest;
    } vec_t;
    vec_t vecs [12];

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic reset_dut();
        in_valid = 1'b0; flush = 1'b0; Reset_n = 1'b0;
        @(negedge Clk);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        logic [22:0] vb;
        logic        m_valid;
        logic [8:0]  m_instr;
        int          m_stall;
        int          fire_cyc[$];
        logic [3:0]  fire_dst[$];

        set_row(0,  3'b000, 8'b1001_0000, 0, 4'd8);
        set_row(1,  3'b000, 8'b1001_0000, 0, 4'd8);
        set_row(2,  3'b000, 8'b1000_0100, 1, 4'd0);
        set_row(3,  3'b000, 8'b1000_0100, 1, 4'd0);
        set_row(4,  3'b000, 8'b0100_0000, 0, 4'd0);
        set_row(5,  3'b000, 8'b0100_0000, 0, 4'd0);
        set_row(6,  3'b011, 8'b1000_0000, 2, 4'd0);
        set_row(7,  3'b011, 8'b1000_0000, 2, 4'd0);
        set_row(8,  3'b000, 8'b1000_0000, 0, 4'd10);
        set_row(9,  3'b101, 8'b1000_0000, 0, 4'd11);
        set_row(10, 3'b110, 8'b1000_0000, 0, 4'd11);
        set_row(11, 3'b100, 8'b1010_0000, 0, 4'd9);
        set_row(12, 3'b000, 8'b1010_0000, 0, 4'd9);
        set_row(13, 3'b010, 8'b1010_0000, 0, 4'd11);
        set_row(14, 3'b001, 8'b0000_0010, 0, 4'd0);
        set_row(15, 3'b000, 8'b1010_1001, 2, 4'd0);

        // Sources avoid r7 so the load (dest r7) never causes a stall here.
        vecs[0]  = '{9'b000_001_010, 3'b000, 8'b1001_0000, 4'd8};   // move
        vecs[1]  = '{9'b001_111_000, 3'b000, 8'b1000_0100, 4'd7};   // load r7
        vecs[2]  = '{9'b010_001_010, 3'b000, 8'b0100_0000, 4'd0};   // store
        vecs[3]  = '{9'b011_010_011, 3'b011, 8'b1000_0000, 4'd3};   // redxor
        vecs[4]  = '{9'b100_001_001, 3'b000, 8'b1000_0000, 4'd10};  // addi
        vecs[5]  = '{9'b100_100_010, 3'b101, 8'b1000_0000, 4'd11};  // lsl
        vecs[6]  = '{9'b101_010_000, 3'b110, 8'b1000_0000, 4'd11};  // lsr
        vecs[7]  = '{9'b101_101_001, 3'b100, 8'b1010_0000, 4'd9};   // pm
        vecs[8]  = '{9'b110_000_000, 3'b000, 8'b1010_0000, 4'd9};   // add
        vecs[9]  = '{9'b110_110_011, 3'b010, 8'b1010_0000, 4'd11};  // xor
        vecs[10] = '{9'b111_001_010, 3'b001, 8'b0000_0010, 4'd0};   // beqr
        vecs[11] = '{9'b111_100_101, 3'b000, 8'b1010_1001, 4'd5};   // copy

        // ---------------- reset state
        Reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = '0;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd0);
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset_bundle",    32'(act_bundle), 32'd0);
        tick();
        Reset_n = 1'b1;

        // ---------------- decode sweep, back-to-back
        out_ready = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (k < 12) begin
                in_valid = 1'b1; in_instr = vecs[k].instr;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge Clk);
            if (k < 12) check("sweep_in_ready", 32'(in_ready), 32'd1);
            if (k > 0) begin
                vb = {vecs[k-1].op, vecs[k-1].ctl, vecs[k-1].dest,
                      1'b0, vecs[k-1].instr[5:3], 1'b0, vecs[k-1].instr[2:0]};
                check("sweep_out_valid", 32'(out_valid), 32'd1);
                check("sweep_bundle", 32'(act_bundle), 32'(vb));
            end
            tick();
        end
        @(negedge Clk);
        check("sweep_drained", 32'(out_valid), 32'd0);
        tick();

        // ---------------- load-use stall
        reset_dut();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 9'b001_011_000;
        @(negedge Clk);
        check("lu_load_ready", 32'(in_ready), 32'd1);
        tick();
        in_instr = 9'b011_011_001;
        stalls = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge Clk);
            if (in_ready) break;
            stalls++;
            tick();
        end
        check("lu_stall_cycles", 32'(stalls), 32'd3);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd3);
        tick();
        in_valid = 1'b0;
        @(negedge Clk);
        check("lu_use_valid", 32'(out_valid), 32'd1);
        check("lu_use_bundle", 32'(act_bundle), 32'(exp_bundle(9'b011_011_001)));
        tick();

        // ---------------- back-pressure
        reset_dut();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 9'b000_001_010;
        @(negedge Clk);
        check("bp_first_ready", 32'(in_ready), 32'd1);
        tick();
        in_instr = 9'b110_000_000;
        for (int n = 0; n < 4; n++) begin
            @(negedge Clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_bundle", 32'(act_bundle), 32'(exp_bundle(9'b000_001_010)));
            check("bp_hold_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge Clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge Clk);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_bundle", 32'(act_bundle), 32'(exp_bundle(9'b110_000_000)));
        tick();
        @(negedge Clk);
        check("bp_drained", 32'(out_valid), 32'd0);
        tick();

        // ---------------- flush of an unissued load
        reset_dut();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 9'b001_101_000;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        @(negedge Clk);
        check("fl_load_held", 32'(out_valid && out_load), 32'd1);
        check("fl_ready_blocked", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_instr = 9'b011_101_000;
        @(negedge Clk);
        check("fl_killed", 32'(out_valid), 32'd0);
        check("fl_reader_not_stalled", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge Clk);
        check("fl_reader_bundle", 32'(act_bundle), 32'(exp_bundle(9'b011_101_000)));
        tick();

        // ---------------- async reset during a stall
        reset_dut();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 9'b001_010_000;
        tick();
        in_instr = 9'b011_010_000;
        for (int n = 0; n < 4; n++) tick();
        out_ready = 1'b1;            // load issues, reader still blocked
        tick();
        @(negedge Clk);
        check("rs_stall_cnt", 32'(stall_cnt), 32'd5);
        check("rs_blocked", 32'(in_ready), 32'd0);
        #2 Reset_n = 1'b0;
        #1;
        check("rs_async_valid", 32'(out_valid), 32'd0);
        check("rs_async_cnt", 32'(stall_cnt), 32'd0);
        check("rs_async_ready", 32'(in_ready), 32'd0);
        tick();
        Reset_n = 1'b1;
        @(negedge Clk);
        check("rs_sb_empty", 32'(in_ready), 32'd1);
        tick();

        // ---------------- randomized run vs. cycle-indexed model
        reset_dut();
        m_valid = 1'b0; m_instr = '0; m_stall = 0;
        for (int c = 0; c < 400; c++) begin
            logic [2:0] opc, hi, lo;
            logic [3:0] sa, sb;
            logic hz, exp_rdy, fire, acc;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            opc = ($urandom_range(0, 2) == 0) ? 3'b001 : 3'($urandom_range(0, 7));
            hi  = 3'($urandom_range(0, 7));
            lo  = 3'($urandom_range(0, 3));
            in_instr = {opc, hi, lo};
            @(negedge Clk);
            sa = {1'b0, hi}; sb = {1'b0, lo};
            hz = 1'b0;
            foreach (fire_cyc[i]) begin
                if ((c - fire_cyc[i] >= 1) && (c - fire_cyc[i] <= LOAD_LAT) &&
                    (fire_dst[i] == sa || fire_dst[i] == sb)) hz = 1'b1;
            end
            if (m_valid && m_instr[8:6] == 3'b001 &&
                ({1'b0, m_instr[5:3]} == sa || {1'b0, m_instr[5:3]} == sb)) hz = 1'b1;
            hz = hz && in_valid;
            exp_rdy = !flush && !hz && (!m_valid || out_ready);
            check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            check("rnd_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) check("rnd_bundle", 32'(act_bundle), 32'(exp_bundle(m_instr)));
            check("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));

            fire = m_valid && out_ready;
            if (fire && m_instr[8:6] == 3'b001) begin
                fire_cyc.push_back(c);
                fire_dst.push_back({1'b0, m_instr[5:3]});
            end
            acc = in_valid && exp_rdy;
            if (hz && m_stall < 65535) m_stall++;
            if (flush)      m_valid = 1'b0;
            else if (acc)   m_valid = 1'b1;
            else if (fire)  m_valid = 1'b0;
            if (acc) m_instr = in_instr;
            while (fire_cyc.size() > 0 && (c - fire_cyc[0] >= LOAD_LAT)) begin
                void'(fire_cyc.pop_front());
                void'(fire_dst.pop_front());
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
